// File: rtl/multimode_reg.sv
// WIDTH-bit register with load, increment and serial shift modes, plus wrap/zero flags.
// Optional shadow load/commit path enabled by defining MULTIMODE_REG_SHADOW_EN.
module multimode_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             ser_in,
  input  logic             commit,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             wrap,
  output logic             zero
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_INC  = 2'b01,
    OP_SHL  = 2'b10,
    OP_SHR  = 2'b11
  } opType;

  logic [WIDTH-1:0] r_q;
  logic             r_serOut;
  logic             r_wrap;

  logic [WIDTH-1:0] w_opQ;
  logic             w_opSer;
  logic             w_opWrap;

  logic [WIDTH-1:0] w_qNext;
  logic             w_serNext;
  logic             w_wrapNext;

  // Result of the en&op datapath, before priority against clr/load/commit.
  always_comb begin
    w_opQ    = r_q;
    w_opSer  = r_serOut;
    w_opWrap = 1'b0;
    case (opType'(op))
      OP_INC: begin
        w_opQ    = r_q + 1'b1;
        w_opWrap = (r_q == '1);
      end
      OP_SHL: begin
        w_opQ   = {r_q[WIDTH-2:0], ser_in};
        w_opSer = r_q[WIDTH-1];
      end
      OP_SHR: begin
        w_opQ   = {ser_in, r_q[WIDTH-1:1]};
        w_opSer = r_q[0];
      end
      default: ;
    endcase
  end

`ifdef MULTIMODE_REG_SHADOW_EN
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadowNext;

  // Load only fills the shadow, so en&op still acts on q unless commit claims the cycle.
  always_comb begin
    w_qNext      = r_q;
    w_serNext    = r_serOut;
    w_wrapNext   = 1'b0;
    w_shadowNext = r_shadow;
    if (clr) begin
      w_qNext      = RESET_VAL;
      w_serNext    = 1'b0;
      w_shadowNext = RESET_VAL;
    end else begin
      if (load) begin
        w_shadowNext = d;
      end
      if (commit) begin
        w_qNext   = r_shadow;
        w_serNext = 1'b0;
      end else if (en) begin
        w_qNext    = w_opQ;
        w_serNext  = w_opSer;
        w_wrapNext = w_opWrap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= RESET_VAL;
    end else begin
      r_shadow <= w_shadowNext;
    end
  end
`else
  logic w_unusedCommit;
  assign w_unusedCommit = commit;

  always_comb begin
    w_qNext    = r_q;
    w_serNext  = r_serOut;
    w_wrapNext = 1'b0;
    if (clr) begin
      w_qNext   = RESET_VAL;
      w_serNext = 1'b0;
    end else if (load) begin
      w_qNext   = d;
      w_serNext = 1'b0;
    end else if (en) begin
      w_qNext    = w_opQ;
      w_serNext  = w_opSer;
      w_wrapNext = w_opWrap;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= RESET_VAL;
      r_serOut <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_q      <= w_qNext;
      r_serOut <= w_serNext;
      r_wrap   <= w_wrapNext;
    end
  end

  assign q       = r_q;
  assign ser_out = r_serOut;
  assign wrap    = r_wrap;
  assign zero    = (r_q == '0);

endmodule

// File: tb/tb_multimode_reg.sv
// Directed bench for multimode_reg: one instance with RESET_VAL=00 and one with RESET_VAL=80.
// Define MULTIMODE_REG_SHADOW_EN for both files to run the shadow load/commit sequence.
module tb_multimode_reg;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [7:0] d;
  logic       en;
  logic [1:0] op;
  logic       ser_in;
  logic       commit;

  logic [7:0] q;
  logic       ser_out;
  logic       wrap;
  logic       zero;

  logic [7:0] q80;
  logic       serOut80;
  logic       wrap80;
  logic       zero80;

  int checkCount;
  int failCount;

  multimode_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .d(d), .en(en), .op(op),
    .ser_in(ser_in), .commit(commit), .q(q), .ser_out(ser_out), .wrap(wrap), .zero(zero)
  );

  multimode_reg #(.WIDTH(8), .RESET_VAL(8'h80)) dut80 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .d(d), .en(en), .op(op),
    .ser_in(ser_in), .commit(commit), .q(q80), .ser_out(serOut80), .wrap(wrap80),
    .zero(zero80)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iClr, input logic iLoad, input logic [7:0] iD,
                               input logic iEn, input logic [1:0] iOp, input logic iSer,
                               input logic iCommit);
    clr    = iClr;
    load   = iLoad;
    d      = iD;
    en     = iEn;
    op     = iOp;
    ser_in = iSer;
    commit = iCommit;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    #12;
    checkOutput("rst_q", q, 8'h00);
    checkOutput("rst_wrap", wrap, 1'b0);
    checkOutput("rst_ser", ser_out, 1'b0);
    checkOutput("rst_zero", zero, 1'b1);
    checkOutput("rst_q80", q80, 8'h80);
    checkOutput("rst_zero80", zero80, 1'b0);
    rst_n = 1'b1;

`ifdef MULTIMODE_REG_SHADOW_EN
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 2'b00, 1'b0, 1'b0); tick;
    checkOutput("sh_load_noq", q, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); tick;
    checkOutput("sh_commit", q, 8'h55);
    applyStimulus(1'b0, 1'b1, 8'h66, 1'b0, 2'b00, 1'b0, 1'b1); tick;
    checkOutput("sh_both_old", q, 8'h55);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); tick;
    checkOutput("sh_commit2", q, 8'h66);
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b1, 2'b01, 1'b0, 1'b0); tick;
    checkOutput("sh_load_inc", q, 8'h67);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b1); tick;
    checkOutput("sh_commit_beats_op", q, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0); tick;
    checkOutput("sh_clr_q", q, 8'h00);
    checkOutput("sh_clr_q80", q80, 8'h80);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); tick;
    checkOutput("sh_clr_shadow", q, 8'h00);
`else
    // Shift-left/right chain starting from A5.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 2'b00, 1'b0, 1'b0); tick;
    checkOutput("load_a5", q, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0); tick;
    checkOutput("shl_q", q, 8'h4B);
    checkOutput("shl_ser", ser_out, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b11, 1'b0, 1'b0); tick;
    checkOutput("shr_q", q, 8'h25);
    checkOutput("shr_ser", ser_out, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b11, 1'b1, 1'b0); tick;
    checkOutput("shr_in1_q", q, 8'h92);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0); tick;
    checkOutput("hold_q", q, 8'h92);
    checkOutput("hold_ser", ser_out, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0); tick;
    checkOutput("shl2_q", q, 8'h24);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0); tick;
    checkOutput("shl3_q", q, 8'h48);
    checkOutput("shl3_ser", ser_out, 1'b0);

    // Increment across the all-ones boundary.
    applyStimulus(1'b0, 1'b1, 8'hFE, 1'b1, 2'b01, 1'b0, 1'b0); tick;
    checkOutput("load_beats_inc", q, 8'hFE);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0); tick;
    checkOutput("inc_ff_q", q, 8'hFF);
    checkOutput("inc_ff_wrap", wrap, 1'b0);
    tick;
    checkOutput("inc_00_q", q, 8'h00);
    checkOutput("inc_00_wrap", wrap, 1'b1);
    checkOutput("inc_00_zero", zero, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0); tick;
    checkOutput("idle_q", q, 8'h00);
    checkOutput("idle_wrap", wrap, 1'b0);

    // Priority: clr wins over load and increment in the same cycle.
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 2'b00, 1'b0, 1'b0); tick;
    checkOutput("load_55", q, 8'h55);
    applyStimulus(1'b1, 1'b1, 8'h12, 1'b1, 2'b01, 1'b0, 1'b0); tick;
    checkOutput("clr_prio_q", q, 8'h00);
    checkOutput("clr_prio_zero", zero, 1'b1);
    checkOutput("clr_q80", q80, 8'h80);
    checkOutput("clr_zero80", zero80, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h12, 1'b0, 2'b00, 1'b0, 1'b0); tick;
    checkOutput("load_12", q, 8'h12);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); tick;
    checkOutput("commit_ignored", q, 8'h12);

    // Asynchronous reset in the middle of counting.
    applyStimulus(1'b0, 1'b1, 8'h36, 1'b0, 2'b00, 1'b0, 1'b0); tick;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0); tick;
    checkOutput("count_37", q, 8'h37);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_q", q, 8'h00);
    checkOutput("async_wrap", wrap, 1'b0);
    checkOutput("async_ser", ser_out, 1'b0);
    checkOutput("async_zero", zero, 1'b1);
    checkOutput("async_q80", q80, 8'h80);
    tick;
    checkOutput("held_rst_q", q, 8'h00);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
